// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-register MIPS decode stage with ready/valid handshake
// Optional register busy scoreboard compiled in by defining DECODE_SCOREBOARD_EN.
module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  raA,
  output logic [4:0]  raB,
  output logic [4:0]  wa,
  output logic        wen,
  output logic [3:0]  op,
  output logic [31:0] imm,
  output logic        use_imm,
  output logic        illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr
);

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic        is_rtype;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm16    = instr[15:0];
  assign is_rtype = (opcode == OPC_RTYPE);

  logic [4:0]  d_raa;
  logic [4:0]  d_rab;
  logic [4:0]  d_wa;
  logic        d_wen;
  logic [3:0]  d_op;
  logic [31:0] d_imm;
  logic        d_use_imm;
  logic        d_illegal;

  // Unsupported encodings fall through to the defaults: op=1111, no write, flagged illegal.
  always_comb begin
    d_raa     = rs;
    d_rab     = rt;
    d_wa      = 5'd0;
    d_wen     = 1'b0;
    d_op      = 4'b1111;
    d_imm     = 32'h0;
    d_use_imm = 1'b0;
    d_illegal = 1'b1;
    if (instr == 32'h0) begin
      d_op      = 4'b0010;
      d_illegal = 1'b0;
    end else if (is_rtype) begin
      case (funct)
        6'h24:   d_op = 4'b0000;
        6'h25:   d_op = 4'b0001;
        6'h20:   d_op = 4'b0010;
        6'h22:   d_op = 4'b0110;
        6'h2A:   d_op = 4'b0111;
        6'h27:   d_op = 4'b1100;
        default: d_op = 4'b1111;
      endcase
      if (d_op != 4'b1111) begin
        d_illegal = 1'b0;
        d_wa      = rd;
        d_wen     = (rd != 5'd0);
      end
    end else begin
      case (opcode)
        OPC_ADDI: begin d_op = 4'b0010; d_imm = {{16{imm16[15]}}, imm16}; end
        OPC_SLTI: begin d_op = 4'b0111; d_imm = {{16{imm16[15]}}, imm16}; end
        OPC_ANDI: begin d_op = 4'b0000; d_imm = {16'h0, imm16}; end
        OPC_ORI:  begin d_op = 4'b0001; d_imm = {16'h0, imm16}; end
        default:  d_op = 4'b1111;
      endcase
      if (d_op != 4'b1111) begin
        d_illegal = 1'b0;
        d_wa      = rt;
        d_wen     = (rt != 5'd0);
        d_use_imm = 1'b1;
      end
    end
  end

  logic hazard;
  logic accept;

  assign in_ready = !reset && (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

`ifdef DECODE_SCOREBOARD_EN
  logic [31:0] busy;
  logic [31:0] busy_nxt;

  // Only the registered vector is consulted; a retirement frees the register one cycle later.
  assign hazard = in_valid && (busy[rs] || (is_rtype && busy[rt]) || busy[d_wa]);

  // Set is applied after clear so a same-cycle issue to a retiring address stays busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_addr] = 1'b0;
    if (accept && d_wen) busy_nxt[d_wa] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) busy <= 32'h0;
    else       busy <= busy_nxt;
  end
`else
  logic unused_wb;

  assign hazard    = 1'b0;
  assign unused_wb = ^{wb_valid, wb_addr};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      raA       <= 5'd0;
      raB       <= 5'd0;
      wa        <= 5'd0;
      wen       <= 1'b0;
      op        <= 4'b0000;
      imm       <= 32'h0;
      use_imm   <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      raA       <= d_raa;
      raB       <= d_rab;
      wa        <= d_wa;
      wen       <= d_wen;
      op        <= d_op;
      imm       <= d_imm;
      use_imm   <= d_use_imm;
      illegal   <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  raA;
  logic [4:0]  raB;
  logic [4:0]  wa;
  logic        wen;
  logic [3:0]  op;
  logic [31:0] imm;
  logic        use_imm;
  logic        illegal;
  logic        wb_valid;
  logic [4:0]  wb_addr;

  always #5 clock = ~clock;

  decode_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .raA(raA), .raB(raB), .wa(wa), .wen(wen), .op(op), .imm(imm),
    .use_imm(use_imm), .illegal(illegal), .wb_valid(wb_valid), .wb_addr(wb_addr)
  );

  typedef struct packed {
    logic [4:0]  ra_a;
    logic [4:0]  ra_b;
    logic [4:0]  wa;
    logic        wen;
    logic [3:0]  op;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
  } dec_t;

  dec_t expq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic dec_t mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] w,
                              input logic we, input logic [3:0] o, input logic [31:0] i,
                              input logic ui, input logic il);
    dec_t d;
    d = '{ra_a: a, ra_b: b, wa: w, wen: we, op: o, imm: i, use_imm: ui, illegal: il};
    return d;
  endfunction

  function automatic dec_t observed();
    dec_t d;
    d = '{ra_a: raA, ra_b: raB, wa: wa, wen: wen, op: op, imm: imm, use_imm: use_imm, illegal: illegal};
    return d;
  endfunction

  // Only op/wen/illegal are defined for an illegal encoding.
  function automatic dec_t masked(input dec_t d);
    dec_t m;
    m = d;
    if (d.illegal) begin
      m = '0;
      m.op = d.op;
      m.wen = d.wen;
      m.illegal = 1'b1;
    end
    return m;
  endfunction

  function automatic dec_t model(input logic [31:0] w);
    dec_t d;
    logic [5:0] opc;
    logic [5:0] fn;
    d   = '0;
    opc = w[31:26];
    fn  = w[5:0];
    if (w == 32'h0) begin
      d.op = 4'b0010;
    end else if (opc == 6'h00) begin
      d.ra_a = w[25:21]; d.ra_b = w[20:16]; d.wa = w[15:11]; d.wen = (w[15:11] != 5'd0);
      case (fn)
        6'h24: d.op = 4'b0000;
        6'h25: d.op = 4'b0001;
        6'h20: d.op = 4'b0010;
        6'h22: d.op = 4'b0110;
        6'h2A: d.op = 4'b0111;
        6'h27: d.op = 4'b1100;
        default: begin d.op = 4'b1111; d.wen = 1'b0; d.illegal = 1'b1; end
      endcase
    end else begin
      d.ra_a = w[25:21]; d.ra_b = w[20:16]; d.wa = w[20:16]; d.wen = (w[20:16] != 5'd0);
      d.use_imm = 1'b1;
      case (opc)
        6'h08: begin d.op = 4'b0010; d.imm = {{16{w[15]}}, w[15:0]}; end
        6'h0A: begin d.op = 4'b0111; d.imm = {{16{w[15]}}, w[15:0]}; end
        6'h0C: begin d.op = 4'b0000; d.imm = {16'h0, w[15:0]}; end
        6'h0D: begin d.op = 4'b0001; d.imm = {16'h0, w[15:0]}; end
        default: begin d.op = 4'b1111; d.wen = 1'b0; d.illegal = 1'b1; end
      endcase
    end
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [6];
    logic [5:0] iops [4];
    logic [31:0] w;
    fns  = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};
    iops = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
    case ($urandom_range(0, 4))
      0: w = {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'h00, fns[$urandom_range(0, 5)]};
      1: w = {iops[$urandom_range(0, 3)], 5'($urandom), 5'($urandom), 16'($urandom)};
      2: w = 32'h0;
      3: w = {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'h00, 6'($urandom)};
      default: w = $urandom;
    endcase
    return w;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic retire(input logic [4:0] a);
    wb_valid = 1'b1;
    wb_addr  = a;
    cyc();
    wb_valid = 1'b0;
    wb_addr  = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; instr = 32'h00331020; out_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = 5'd0;
    cyc(); cyc();
    @(negedge clock);
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    else ; 
    if (in_ready !== 1'b0) errors++;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (observed() !== dec_t'(0)) begin errors++; $display("FAIL reset_outputs: got %h expected 0", observed()); end
    cyc();
    reset = 1'b0; in_valid = 1'b0; instr = 32'h0;
  endtask

  task automatic test_rtype();
    dec_t e;
    in_valid = 1'b1; instr = 32'h00331020; out_ready = 1'b1;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rtype_in_ready: got %b expected 1", in_ready); end
    if (in_valid && in_ready) expq.push_back(mk(5'd1, 5'd19, 5'd2, 1'b1, 4'b0010, 32'h0, 1'b0, 1'b0));
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (!(out_valid === 1'b1 && expq.size() > 0)) begin
      errors++; $display("FAIL rtype_out_valid: got %b expected 1", out_valid);
    end else begin
      e = expq.pop_front();
      checks++;
      if (masked(observed()) !== masked(e)) begin errors++; $display("FAIL rtype_add: got %h expected %h", observed(), e); end
    end
    cyc();
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rtype_drain: got %b expected 0", out_valid); end
    cyc();
  endtask

  // Relies on $2 still being busy from test_rtype's add.
  task automatic test_hazard();
    dec_t e;
    in_valid = 1'b1; instr = 32'h00422822; out_ready = 1'b1;
`ifdef DECODE_SCOREBOARD_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_stall: got %b expected 0", in_ready); end
      cyc();
    end
    wb_valid = 1'b1; wb_addr = 5'd2;
    @(negedge clock);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_no_bypass: got %b expected 0", in_ready); end
    cyc();
    wb_valid = 1'b0; wb_addr = 5'd0;
`endif
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: got %b expected 1", in_ready); end
    if (in_valid && in_ready) expq.push_back(mk(5'd2, 5'd2, 5'd5, 1'b1, 4'b0110, 32'h0, 1'b0, 1'b0));
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (!(out_valid === 1'b1 && expq.size() > 0)) begin
      errors++; $display("FAIL hazard_out_valid: got %b expected 1", out_valid);
    end else begin
      e = expq.pop_front();
      checks++;
      if (masked(observed()) !== masked(e)) begin errors++; $display("FAIL hazard_sub: got %h expected %h", observed(), e); end
    end
    cyc();
    retire(5'd5);
  endtask

  task automatic test_itype();
    dec_t e;
    in_valid = 1'b1; instr = 32'h2003FFFF; out_ready = 1'b1;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready: got %b expected 1", in_ready); end
    if (in_valid && in_ready) expq.push_back(mk(5'd0, 5'd3, 5'd3, 1'b1, 4'b0010, 32'hFFFFFFFF, 1'b1, 1'b0));
    cyc();
    instr = 32'h34048000;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ori_in_ready: got %b expected 1", in_ready); end
    if (out_valid === 1'b1 && expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (masked(observed()) !== masked(e)) begin errors++; $display("FAIL itype_addi: got %h expected %h", observed(), e); end
    end else begin
      checks++; errors++; $display("FAIL addi_out_valid: got %b expected 1", out_valid);
    end
    if (in_valid && in_ready) expq.push_back(mk(5'd0, 5'd4, 5'd4, 1'b1, 4'b0001, 32'h00008000, 1'b1, 1'b0));
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    if (out_valid === 1'b1 && expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (masked(observed()) !== masked(e)) begin errors++; $display("FAIL itype_ori: got %h expected %h", observed(), e); end
    end else begin
      checks++; errors++; $display("FAIL ori_out_valid: got %b expected 1", out_valid);
    end
    cyc();
    retire(5'd3);
    retire(5'd4);
  endtask

  task automatic test_stall();
    dec_t e;
    in_valid = 1'b1; instr = 32'h302600F0; out_ready = 1'b1;
    @(negedge clock);
    if (in_valid && in_ready) expq.push_back(mk(5'd1, 5'd6, 5'd6, 1'b1, 4'b0000, 32'h000000F0, 1'b1, 1'b0));
    cyc();
    instr = 32'h34070001; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
      checks++;
      if (expq.size() == 0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL stall_out_valid: got %b expected 1", out_valid);
      end else if (masked(observed()) !== masked(expq[0])) begin
        errors++; $display("FAIL stall_hold: got %h expected %h", observed(), expq[0]);
      end
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", in_ready); end
    if (out_valid === 1'b1 && expq.size() > 0) e = expq.pop_front();
    if (in_valid && in_ready) expq.push_back(mk(5'd0, 5'd7, 5'd7, 1'b1, 4'b0001, 32'h00000001, 1'b1, 1'b0));
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (!(out_valid === 1'b1 && expq.size() > 0)) begin
      errors++; $display("FAIL stall_next_valid: got %b expected 1", out_valid);
    end else begin
      e = expq.pop_front();
      if (masked(observed()) !== masked(e)) begin errors++; $display("FAIL stall_next: got %h expected %h", observed(), e); end
    end
    cyc();
    retire(5'd6);
    retire(5'd7);
  endtask

  task automatic test_illegal_reset();
    dec_t e;
    in_valid = 1'b1; instr = 32'h00331020; out_ready = 1'b1;
    @(negedge clock);
    if (in_valid && in_ready) expq.push_back(mk(5'd1, 5'd19, 5'd2, 1'b1, 4'b0010, 32'h0, 1'b0, 1'b0));
    cyc();
    instr = 32'hFC000000;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL illegal_in_ready: got %b expected 1", in_ready); end
    if (out_valid === 1'b1 && expq.size() > 0) e = expq.pop_front();
    if (in_valid && in_ready) expq.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 4'b1111, 32'h0, 1'b0, 1'b1));
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (expq.size() == 0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL illegal_out_valid: got %b expected 1", out_valid);
      end else if (masked(observed()) !== masked(expq[0])) begin
        errors++; $display("FAIL illegal_decode: got %h expected %h", observed(), expq[0]);
      end
      cyc();
    end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_stall_in_ready: got %b expected 0", in_ready); end
    cyc();
    reset = 1'b0;
    expq.delete();
    in_valid = 1'b1; instr = 32'h00422822; out_ready = 1'b1;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_discard: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_busy_clear: got %b expected 1", in_ready); end
    if (in_valid && in_ready) expq.push_back(mk(5'd2, 5'd2, 5'd5, 1'b1, 4'b0110, 32'h0, 1'b0, 1'b0));
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    if (out_valid === 1'b1 && expq.size() > 0) e = expq.pop_front();
    cyc();
    retire(5'd5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog[$];
    dec_t        e;
    int          idx;
    int          got;
    int          n;
    logic        pend_v;
    logic [4:0]  pend_a;
    idx = 0; got = 0; n = 40; pend_v = 1'b0; pend_a = 5'd0;
    for (int i = 0; i < n; i++) prog.push_back(rand_instr());
    for (int c = 0; c < 600 && got < n; c++) begin
      in_valid = (idx < n);
      if (idx < n) instr = prog[idx];
      else instr = 32'h0;
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid = pend_v; wb_addr = pend_a; pend_v = 1'b0;
      @(negedge clock);
`ifndef DECODE_SCOREBOARD_EN
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL b2b_in_ready: got %b expected %b", in_ready, (!out_valid || out_ready));
      end
`endif
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected: got %h expected none", observed());
        end else begin
          e = expq.pop_front();
          if (masked(observed()) !== masked(e)) begin errors++; $display("FAIL b2b_decode: got %h expected %h", observed(), e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        e = model(instr);
        expq.push_back(e);
        if (e.wen) begin pend_v = 1'b1; pend_a = e.wa; end
        idx++;
      end
      cyc();
    end
    in_valid = 1'b0; wb_valid = 1'b0; wb_addr = 5'd0; out_ready = 1'b1;
    checks++; if (got != n) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got, n); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_hazard();
    test_itype();
    test_stall();
    test_illegal_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clock  in  1  sole clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  instr is valid this cycle.
REQ-004 in_ready  out  1  stage accepts instr this cycle; a transfer occurs when in_valid && in_ready.
REQ-005 instr  in  32  MIPS instruction word.
REQ-006 out_valid  out  1  registered decode outputs are valid.
REQ-007 out_ready  in  1  downstream RegFile/ALU consumes the outputs this cycle.
REQ-008 raA, raB  out  5 each  RegFile read addresses.
REQ-009 wa  out  5  RegFile write address; wen  out  1  write enable.
REQ-010 op  out  4  ALU operation code.
REQ-011 imm  out  32  extended immediate; use_imm  out  1  ALU B operand is imm instead of rdB.
REQ-012 illegal  out  1  unsupported instruction flag.
REQ-013 wb_valid  in  1 and wb_addr  in  5  downstream retirement of a write to wb_addr.

Function
REQ-014 The stage SHALL hold one output register; latency is 1 cycle from accepted transfer to out_valid=1.
REQ-015 in_ready SHALL equal (!out_valid || out_ready) && !hazard, where hazard is defined in REQ-024.
REQ-016 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-017 When out_valid && out_ready and no new transfer occurs, out_valid SHALL drop to 0 next cycle.
REQ-018 R-type (opcode 0) SHALL give raA=rs, raB=rt, wa=rd, wen=(rd!=0), use_imm=0, with funct mapping 0x24 AND->0000, 0x25 OR->0001, 0x20 ADD->0010, 0x22 SUB->0110, 0x2A SLT->0111, 0x27 NOR->1100.
REQ-019 I-type SHALL give raA=rs, raB=rt, wa=rt, wen=(rt!=0), use_imm=1, with ADDI 0x08->0010 sign-extended, SLTI 0x0A->0111 sign-extended, ANDI 0x0C->0000 zero-extended, ORI 0x0D->0001 zero-extended.
REQ-020 instr==32'h0 SHALL decode as NOP: wen=0, op=0010, illegal=0.
REQ-021 Any other encoding SHALL give op=1111, wen=0, illegal=1, and still pass through with out_valid.
REQ-022 For R-type instructions imm SHALL be 0.
REQ-023 Scoreboard: a 32-bit busy vector; on an accepted transfer with wen=1, busy[wa] SHALL be set; on wb_valid, busy[wb_addr] SHALL be cleared.
REQ-024 hazard SHALL be in_valid && (busy[rs] || (R-type && busy[rt]) || busy[dest]), using only the registered busy vector (no same-cycle wb bypass).
REQ-025 A same-cycle set and clear of the same address SHALL leave it set.
REQ-026 busy[0] SHALL always read 0; wb_addr=0 is ignored.

Reset
REQ-027 While reset=1, out_valid=0, busy=0, and raA=raB=wa=0, wen=0, op=0000, imm=0, use_imm=0, illegal=0.
REQ-028 Reset asserted mid-stall SHALL discard the held instruction.
REQ-029 in_ready SHALL be 0 during the reset cycle.

Configuration
REQ-030 The macro DECODE_SCOREBOARD_EN SHALL compile the scoreboard in.
REQ-031 With DECODE_SCOREBOARD_EN defined, REQ-023 to REQ-026 apply.
REQ-032 With DECODE_SCOREBOARD_EN undefined, hazard SHALL be constant 0, no busy storage SHALL be present, and wb_valid/wb_addr SHALL be ignored.

Verification
REQ-033 instr=0x00331020 (add $2,$1,$19), out_ready=1 -> next cycle out_valid=1, raA=1, raB=19, wa=2, wen=1, op=0010, use_imm=0.
REQ-034 instr=0x2003FFFF (addi $3,$0,-1) -> imm=0xFFFFFFFF, wa=3, op=0010, use_imm=1; then instr=0x34048000 (ori $4,$0,0x8000) -> imm=0x00008000, op=0001.
REQ-035 With EN defined, issue 0x00331020, then present 0x00422822 (sub $5,$2,$2) -> in_ready=0 until the cycle after wb_valid=1 with wb_addr=2, then the transfer is accepted; with EN undefined -> accepted in the next cycle.
REQ-036 out_ready=0 for 5 cycles with in_valid=1 -> outputs unchanged and in_ready=0 throughout.
REQ-037 instr=0xFC000000 -> op=1111, illegal=1, wen=0; assert reset while a decode is held -> next cycle out_valid=0 and busy is cleared.
